// File: rtl/imem_pkg.sv
// imem_pkg: shared state encoding, fault word and width helper for the instruction-memory responder.
package imem_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_e;
   localparam logic [31:0] FAULT_INSTR = 32'h0000_0000;
   function automatic int unsigned width_of(input int unsigned n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction
endpackage

// File: rtl/imem_array.sv
// imem_array: DEPTH x 32 instruction store, one sync write port and one registered read port.
// A same-edge write and read of one word returns the old contents.
module imem_array
   import imem_pkg::*;
#(
   parameter  int unsigned DEPTH = 256,
   localparam int unsigned AW    = width_of(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [31:0]   wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   output logic [31:0]   rd_data
);
   logic [31:0] mem [DEPTH];
   logic [31:0] rd_data_q, rd_data_d;
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
   end
   always_comb rd_data_d = rd_en ? mem[rd_addr] : rd_data_q;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) rd_data_q <= '0;
      else        rd_data_q <= rd_data_d;
   end
   assign rd_data = rd_data_q;
endmodule

// File: rtl/imem_fetch_responder.sv
// imem_fetch_responder: fixed-latency instruction fetch responder with load port and flush.
// Define IMEM_CHECK_EN to flag misaligned / out-of-range fetches on rsp_err.
module imem_fetch_responder
   import imem_pkg::*;
#(
   parameter  int unsigned DEPTH   = 256,
   parameter  int unsigned LATENCY = 2,
   localparam int unsigned AW      = width_of(DEPTH)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          flush,
   input  logic          req_valid,
   output logic          req_ready,
   input  logic [31:0]   req_addr,
   output logic          rsp_valid,
   input  logic          rsp_ready,
   output logic [31:0]   rsp_instr,
   output logic          rsp_err,
   input  logic          ld_en,
   input  logic [AW-1:0] ld_addr,
   input  logic [31:0]   ld_data
);
   localparam int unsigned CW = width_of(LATENCY);
   state_e        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [AW-1:0] idx_q, idx_d;
   logic          err_q, err_d;
   logic          rsp_err_q, rsp_err_d;
   logic          accept, rd_en, req_err;
   logic [AW-1:0] req_idx, rd_addr;
   logic [31:0]   rd_data;

   assign req_idx = req_addr[AW+1:2];
`ifdef IMEM_CHECK_EN
   assign req_err = (req_addr[1:0] != 2'b00) || ((req_addr >> (AW + 2)) != 32'd0);
`else
   logic addr_unused;
   assign addr_unused = ^{req_addr[31:AW+2], req_addr[1:0]};
   assign req_err     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         idx_q     <= '0;
         err_q     <= 1'b0;
         rsp_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         err_q     <= err_d;
         rsp_err_q <= rsp_err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      idx_d   = accept ? req_idx : idx_q;
      err_d   = accept ? req_err : err_q;
      if (flush)                             state_d = IDLE;
      else if (accept) begin
         state_d = (LATENCY == 1) ? RESP : BUSY;
         cnt_d   = CW'(LATENCY - 1);
      end else if (state_q == BUSY) begin
         cnt_d   = cnt_q - CW'(1);
         state_d = (cnt_q == CW'(1)) ? RESP : BUSY;
      end else if (state_q == RESP && rsp_ready) state_d = IDLE;
      rsp_err_d = rd_en ? (accept ? req_err : err_q) : rsp_err_q;
   end

   // the read edge is the one entering RESP; with LATENCY=1 that is the accept edge itself
   always_comb begin
      req_ready = rst_n && !flush && (state_q == IDLE || (state_q == RESP && rsp_ready));
      accept    = req_valid && req_ready;
      rsp_valid = state_q == RESP;
      rd_en     = (LATENCY == 1) ? accept : (state_q == BUSY && cnt_q == CW'(1));
      rd_addr   = accept ? req_idx : idx_q;
   end

   imem_array #(.DEPTH(DEPTH)) u_array (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (ld_en),
      .wr_addr (ld_addr),
      .wr_data (ld_data),
      .rd_en   (rd_en),
      .rd_addr (rd_addr),
      .rd_data (rd_data)
   );

   assign rsp_err   = rsp_err_q;
   assign rsp_instr = rsp_err_q ? FAULT_INSTR : rd_data;
endmodule
